// File: rtl/display_mux_scheduler.sv
// Scans DIGITS common-anode digits through one shared segment decoder, one digit per dwell.
// Define MUX_BLANKING_EN to insert an all-off BLANK gap between digits against ghosting.
module display_mux_scheduler #(
    parameter int DIGITS       = 2,
    parameter int DWELL_CYCLES = 24000,
    parameter int BLANK_CYCLES = 240
) (
    input  logic                  internal_oscillator,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [4*DIGITS-1:0]   digit_values,
    output logic [3:0]            selected_value,
    output logic [DIGITS-1:0]     anode_enables,
    output logic                  frame_done
);

    localparam int CNT_MAX = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int IDX_W   = $clog2(DIGITS);

    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(DIGITS - 1);

`ifdef MUX_BLANKING_EN
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    typedef enum logic [1:0] {IDLE, BLANK, DWELL} state_t;
`else
    typedef enum logic {IDLE, DWELL} state_t;
`endif

    state_t            state;
    logic [IDX_W-1:0]  digit_idx;
    logic [CNT_W-1:0]  phase_cnt;
    logic [IDX_W-1:0]  next_idx;
    logic              last_digit;

    function automatic logic [3:0] digit_at(input logic [4*DIGITS-1:0] vals,
                                            input logic [IDX_W-1:0]    idx);
        return vals[4*int'(idx) +: 4];
    endfunction

    function automatic logic [DIGITS-1:0] anode_for(input logic [IDX_W-1:0] idx);
        return ~(DIGITS'(1) << idx);
    endfunction

    assign last_digit = (digit_idx == IDX_LAST);
    assign next_idx   = last_digit ? '0 : digit_idx + 1'b1;

    always_ff @(posedge internal_oscillator) begin
        if (reset) begin
            state          <= IDLE;
            digit_idx      <= '0;
            phase_cnt      <= '0;
            selected_value <= 4'h0;
            anode_enables  <= '1;
            frame_done     <= 1'b0;
        end else if (!enable) begin
            // Abandon any partial dwell; selected_value keeps its last value.
            state         <= IDLE;
            digit_idx     <= '0;
            phase_cnt     <= '0;
            anode_enables <= '1;
            frame_done    <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    digit_idx      <= '0;
                    phase_cnt      <= '0;
                    selected_value <= digit_at(digit_values, '0);
`ifdef MUX_BLANKING_EN
                    state          <= BLANK;
                    anode_enables  <= '1;
`else
                    state          <= DWELL;
                    anode_enables  <= anode_for('0);
`endif
                end
`ifdef MUX_BLANKING_EN
                BLANK: begin
                    if (phase_cnt == BLANK_LAST) begin
                        state         <= DWELL;
                        phase_cnt     <= '0;
                        anode_enables <= anode_for(digit_idx);
                    end else begin
                        phase_cnt <= phase_cnt + 1'b1;
                    end
                end
`endif
                DWELL: begin
                    if (phase_cnt == DWELL_LAST) begin
                        phase_cnt      <= '0;
                        digit_idx      <= next_idx;
                        frame_done     <= last_digit;
                        // Value is latched here and held until the next digit change.
                        selected_value <= digit_at(digit_values, next_idx);
`ifdef MUX_BLANKING_EN
                        state          <= BLANK;
                        anode_enables  <= '1;
`else
                        state          <= DWELL;
                        anode_enables  <= anode_for(next_idx);
`endif
                    end else begin
                        phase_cnt <= phase_cnt + 1'b1;
                    end
                end
                default: begin
                    state         <= IDLE;
                    anode_enables <= '1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_display_mux_scheduler.sv
// Directed bench for display_mux_scheduler (DIGITS=2, DWELL=4, BLANK=2); follows MUX_BLANKING_EN.
module tb_display_mux_scheduler;

    localparam int DIGITS       = 2;
    localparam int DWELL_CYCLES = 4;
    localparam int BLANK_CYCLES = 2;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 enable;
    logic [4*DIGITS-1:0]  digit_values;
    logic [3:0]           selected_value;
    logic [DIGITS-1:0]    anode_enables;
    logic                 frame_done;

    int   checks  = 0;
    int   errors  = 0;
    bit   started = 1'b0;
    logic [6:0] sb_q[$];

    display_mux_scheduler #(
        .DIGITS       (DIGITS),
        .DWELL_CYCLES (DWELL_CYCLES),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) dut (
        .internal_oscillator (clk),
        .reset               (reset),
        .enable              (enable),
        .digit_values        (digit_values),
        .selected_value      (selected_value),
        .anode_enables       (anode_enables),
        .frame_done          (frame_done)
    );

    always #5 clk = ~clk;

    // At most one anode may be low at any time.
    always @(negedge clk) begin
        if (started) begin
            checks++;
            assert ($countones(~anode_enables) <= 1) else begin
                errors++;
                $error("FAIL one_hot_anode: observed an=%b, required at most one low bit", anode_enables);
            end
        end
    end

    task automatic cycles(input string tag, input int n, input logic [1:0] an,
                          input logic [3:0] sv, input logic fd);
        logic [6:0] exp_v;
        logic [6:0] obs_v;
        for (int i = 0; i < n; i++) begin
            sb_q.push_back({an, sv, fd});
            @(posedge clk);
            #1;
            exp_v = sb_q.pop_front();
            obs_v = {anode_enables, selected_value, frame_done};
            checks++;
            assert (obs_v === exp_v) else begin
                errors++;
                $error("FAIL %s[%0d]: observed an=%b sel=%h fd=%b, expected an=%b sel=%h fd=%b",
                       tag, i, obs_v[6:5], obs_v[4:1], obs_v[0], exp_v[6:5], exp_v[4:1], exp_v[0]);
            end
        end
    endtask

    initial begin
        reset        = 1'b1;
        enable       = 1'b1;
        digit_values = 8'h5A;
        cycles("reset", 1, 2'b11, 4'h0, 1'b0);
        started = 1'b1;
        cycles("reset", 2, 2'b11, 4'h0, 1'b0);
        reset = 1'b0;
`ifdef MUX_BLANKING_EN
        cycles("blank0",      2, 2'b11, 4'hA, 1'b0);
        cycles("dwell0",      4, 2'b10, 4'hA, 1'b0);
        cycles("blank1",      2, 2'b11, 4'h5, 1'b0);
        cycles("dwell1",      4, 2'b01, 4'h5, 1'b0);
        cycles("frame_done",  1, 2'b11, 4'hA, 1'b1);
        cycles("blank0b",     1, 2'b11, 4'hA, 1'b0);
        cycles("dwell0b",     1, 2'b10, 4'hA, 1'b0);
        digit_values = 8'h3C;
        cycles("frozen",      3, 2'b10, 4'hA, 1'b0);
        cycles("blank1c",     2, 2'b11, 4'h3, 1'b0);
        cycles("dwell1c",     4, 2'b01, 4'h3, 1'b0);
        cycles("frame_done2", 1, 2'b11, 4'hC, 1'b1);
        cycles("blank0c",     1, 2'b11, 4'hC, 1'b0);
        cycles("dwell0c",     4, 2'b10, 4'hC, 1'b0);
        cycles("blank1d",     2, 2'b11, 4'h3, 1'b0);
        cycles("dwell1d",     2, 2'b01, 4'h3, 1'b0);
        enable = 1'b0;
        cycles("disable",     2, 2'b11, 4'h3, 1'b0);
        enable = 1'b1;
        cycles("reblank",     2, 2'b11, 4'hC, 1'b0);
        cycles("relight",     2, 2'b10, 4'hC, 1'b0);
        reset = 1'b1;
        cycles("reset_mid",   2, 2'b11, 4'h0, 1'b0);
        reset = 1'b0;
        cycles("restart",     2, 2'b11, 4'hC, 1'b0);
        cycles("restart_dw",  1, 2'b10, 4'hC, 1'b0);
`else
        cycles("dwell0",      4, 2'b10, 4'hA, 1'b0);
        cycles("dwell1",      4, 2'b01, 4'h5, 1'b0);
        cycles("frame_done",  1, 2'b10, 4'hA, 1'b1);
        cycles("dwell0b",     1, 2'b10, 4'hA, 1'b0);
        digit_values = 8'h3C;
        cycles("frozen",      2, 2'b10, 4'hA, 1'b0);
        cycles("dwell1c",     4, 2'b01, 4'h3, 1'b0);
        cycles("frame_done2", 1, 2'b10, 4'hC, 1'b1);
        cycles("dwell0c",     3, 2'b10, 4'hC, 1'b0);
        cycles("dwell1d",     2, 2'b01, 4'h3, 1'b0);
        enable = 1'b0;
        cycles("disable",     2, 2'b11, 4'h3, 1'b0);
        enable = 1'b1;
        cycles("relight",     2, 2'b10, 4'hC, 1'b0);
        reset = 1'b1;
        cycles("reset_mid",   2, 2'b11, 4'h0, 1'b0);
        reset = 1'b0;
        cycles("restart",     1, 2'b10, 4'hC, 1'b0);
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
